// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU and load writeback paths.
// Each source owns a one-entry buffer; entries commit oldest-first, with round-robin on same-edge ties.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [ADDR_WIDTH-1:0] mem_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  reg_write_o,
  output logic [ADDR_WIDTH-1:0] wr_register_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [31:0]           pending_o
);

  function automatic logic [31:0] rd_onehot(input logic [ADDR_WIDTH-1:0] rd);
    logic [31:0] dec;
    dec = '0;
    dec[rd] = 1'b1;
    return dec;
  endfunction

  logic                  alu_full, mem_full;
  logic                  alu_age, mem_age;
  logic                  rr;
  logic [ADDR_WIDTH-1:0] alu_rd, mem_rd;
  logic [DATA_WIDTH-1:0] alu_data, mem_data;

  logic grant_alu, grant_mem, tie;
  logic alu_load, mem_load;
  logic alu_full_nxt, mem_full_nxt;
  logic alu_age_nxt, mem_age_nxt;

  // Grant depends only on buffer state, never on the incoming valids.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    tie       = 1'b0;
    if (alu_full && mem_full) begin
      if (alu_age != mem_age) begin
        grant_alu = alu_age;
        grant_mem = mem_age;
      end else begin
        tie       = 1'b1;
        grant_alu = ~rr;
        grant_mem = rr;
      end
    end else begin
      grant_alu = alu_full;
      grant_mem = mem_full;
    end
  end

  assign alu_ready_o = ~alu_full | grant_alu;
  assign mem_ready_o = ~mem_full | grant_mem;

  // Writes to x0 are accepted but consumed without buffering.
  assign alu_load = alu_valid_i & alu_ready_o & (alu_rd_i != '0);
  assign mem_load = mem_valid_i & mem_ready_o & (mem_rd_i != '0);

  assign alu_full_nxt = alu_load | (alu_full & ~grant_alu);
  assign mem_full_nxt = mem_load | (mem_full & ~grant_mem);

  always_comb begin
    alu_age_nxt = alu_full_nxt;
    mem_age_nxt = mem_full_nxt;
    if (alu_full_nxt && mem_full_nxt) begin
      if (alu_load && mem_load) begin
        alu_age_nxt = 1'b0;
        mem_age_nxt = 1'b0;
      end else if (alu_load) begin
        alu_age_nxt = 1'b0;
        mem_age_nxt = 1'b1;
      end else if (mem_load) begin
        alu_age_nxt = 1'b1;
        mem_age_nxt = 1'b0;
      end else begin
        alu_age_nxt = alu_age;
        mem_age_nxt = mem_age;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      alu_full <= 1'b0;
      mem_full <= 1'b0;
      alu_age  <= 1'b0;
      mem_age  <= 1'b0;
      rr       <= 1'b0;
    end else begin
      alu_full <= alu_full_nxt;
      mem_full <= mem_full_nxt;
      alu_age  <= alu_age_nxt;
      mem_age  <= mem_age_nxt;
      if (tie) rr <= ~rr;
    end
  end

  // Payload registers carry no reset; full gates every use of them.
  always_ff @(posedge clock_i) begin
    if (alu_load) begin
      alu_rd   <= alu_rd_i;
      alu_data <= alu_data_i;
    end
    if (mem_load) begin
      mem_rd   <= mem_rd_i;
      mem_data <= mem_data_i;
    end
  end

  assign reg_write_o   = grant_alu | grant_mem;
  assign wr_register_o = grant_alu ? alu_rd   : (grant_mem ? mem_rd   : '0);
  assign wr_data_o     = grant_alu ? alu_data : (grant_mem ? mem_data : '0);

  assign pending_o = (alu_full ? rd_onehot(alu_rd) : 32'd0) |
                     (mem_full ? rd_onehot(mem_rd) : 32'd0);

endmodule
